// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped 8N1 UART transmitter with TX FIFO, CSR and debug taps
// Ports: clk/rst (async active-low) | wen, ren, addr (0=DATA, 1=CSR), wdata: bus store/load strobes
//        rdata: registered load data | uart_tx: serial line, idle high
//        uart_io_reg: last byte accepted into DATA | uart_csr_reg: live CSR value
module uart_tx_responder #(
   parameter int FIFO_DEPTH  = 8,
   parameter int DEFAULT_DIV = 434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wen,
   input  logic        ren,
   input  logic        addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        uart_tx,
   output logic [31:0] uart_io_reg,
   output logic [31:0] uart_csr_reg
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_n;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic [15:0] div, div_l, div_l_n, baud_cnt, baud_n;
   logic [7:0] shift, shift_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic ovf, full, empty, push, pop, bit_end, tx_n;
   logic unused_wdata;
   assign unused_wdata = ^wdata[15:8];
   assign full  = count == (AW+1)'(FIFO_DEPTH);
   assign empty = count == '0;
   // fullness is judged before this cycle's pop, so a push at full is always dropped
   assign push  = wen && !addr && !full;
   assign pop   = state == IDLE && !empty;
   assign bit_end = baud_cnt == div_l - 16'd1;
   assign uart_csr_reg = {div, 8'(count), 4'b0, ovf, empty, full, state != IDLE};
   always_comb begin
      state_n   = state;
      shift_n   = shift;
      bit_idx_n = bit_idx;
      div_l_n   = div_l;
      baud_n    = bit_end ? 16'd0 : baud_cnt + 16'd1;
      unique case (state)
         IDLE: begin
            baud_n = 16'd0;
            if (pop) begin
               state_n = START;
               shift_n = mem[rd_ptr];
               div_l_n = div == 16'd0 ? 16'd1 : div;
            end
         end
         START: if (bit_end) begin
            state_n   = DATA;
            bit_idx_n = 3'd0;
         end
         DATA: if (bit_end) begin
            shift_n   = shift >> 1;
            bit_idx_n = bit_idx + 3'd1;
            state_n   = bit_idx == 3'd7 ? STOP : DATA;
         end
         STOP: if (bit_end) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // line level is registered from the next state so it changes together with state
      tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
   end
   always_ff @(posedge clk) if (push) mem[wr_ptr] <= wdata[7:0];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         shift       <= '0;
         bit_idx     <= '0;
         div_l       <= 16'(DEFAULT_DIV);
         baud_cnt    <= '0;
         uart_tx     <= 1'b1;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         ovf         <= 1'b0;
         div         <= 16'(DEFAULT_DIV);
         uart_io_reg <= '0;
         rdata       <= '0;
      end else begin
         state    <= state_n;
         shift    <= shift_n;
         bit_idx  <= bit_idx_n;
         div_l    <= div_l_n;
         baud_cnt <= baud_n;
         uart_tx  <= tx_n;
         wr_ptr   <= push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr   <= pop ? rd_ptr + AW'(1) : rd_ptr;
         count    <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (push) uart_io_reg <= {24'b0, wdata[7:0]};
         if (wen && addr) div <= wdata[31:16];
         // an overflow set takes priority over a same-cycle clear
         if (wen && !addr && full) ovf <= 1'b1;
         else if (wen && addr && wdata[3]) ovf <= 1'b0;
         if (ren) rdata <= addr ? uart_csr_reg : uart_io_reg;
      end
   end
endmodule

// File: tb/tb_uart_tx_responder.sv
// tb_uart_tx_responder: scoreboard bench for uart_tx_responder (load data and serial frames)
module tb_uart_tx_responder;
   logic clk, rst, wen, ren, addr;
   logic [31:0] wdata, rdata, uart_io_reg, uart_csr_reg;
   logic uart_tx;
   typedef struct {
      logic [7:0] data;
      int div;
      bit b2b;
      bit abort;
   } frame_t;
   frame_t fq[$];
   logic [31:0] rq[$];
   int checks = 0, errors = 0, cyc = 0, last_end = -100;
   bit mon_busy = 0;
   uart_tx_responder dut (
      .clk(clk), .rst(rst), .wen(wen), .ren(ren), .addr(addr), .wdata(wdata),
      .rdata(rdata), .uart_tx(uart_tx), .uart_io_reg(uart_io_reg), .uart_csr_reg(uart_csr_reg)
   );
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask
   task automatic wr(input logic a, input logic [31:0] d);
      addr = a; wdata = d; wen = 1;
      @(posedge clk); #1 wen = 0;
   endtask
   task automatic rd(input logic a, input logic [31:0] exp);
      addr = a; ren = 1; rq.push_back(exp);
      @(posedge clk); #1 ren = 0;
   endtask
   task automatic send(input logic [7:0] b, input int d, input bit b2b, input bit ab);
      fq.push_back('{data: b, div: d, b2b: b2b, abort: ab});
      wr(0, {24'b0, b});
   endtask
   task automatic measure_busy(input int exp);
      int t = 0, n = 0;
      while (!uart_csr_reg[0] && t < 10) begin @(posedge clk); #1 t++; end
      while (uart_csr_reg[0] && n < 500) begin @(posedge clk); #1 n++; end
      chk("busy_len", n, exp);
   endtask
   task automatic wait_idle();
      int t = 0;
      while ((fq.size() != 0 || mon_busy || uart_csr_reg[0]) && t < 5000) begin @(posedge clk); #1 t++; end
      checks++;
      if (t >= 5000) begin
         errors++;
         $display("FAIL drain_timeout: got %0d frames pending expected 0", fq.size());
      end
   endtask
   initial begin : rd_monitor
      logic [31:0] e;
      forever begin
         @(posedge clk);
         if (ren && rst) begin
            e = rq.size() != 0 ? rq.pop_front() : 32'hDEAD_BEEF;
            @(negedge clk);
            chk("rdata", rdata, e);
         end
      end
   end
   initial begin : tx_monitor
      frame_t f;
      int d, k, start;
      logic [7:0] b;
      bit ok, ab;
      forever begin
         @(negedge clk);
         if (rst && !uart_tx) begin
            mon_busy = 1;
            start = cyc;
            if (fq.size() != 0) f = fq.pop_front();
            else begin
               f.data = 8'h00; f.div = 1; f.b2b = 0; f.abort = 0;
               checks++; errors++;
               $display("FAIL unexpected_frame: got start bit expected idle line");
            end
            d = f.div == 0 ? 1 : f.div;
            ok = 1; ab = 0; b = 8'h00;
            for (int i = 0; i < 10 * d; i++) begin
               if (i > 0) @(negedge clk);
               if (!rst) begin ab = 1; break; end
               k = i / d;
               if (!uart_csr_reg[0]) ok = 0;
               if (k == 0) begin if (uart_tx !== 1'b0) ok = 0; end
               else if (k == 9) begin if (uart_tx !== 1'b1) ok = 0; end
               else if (i % d == 0) b[k-1] = uart_tx;
               else if (uart_tx !== b[k-1]) ok = 0;
            end
            if (f.abort || ab) chk("frame_abort", {31'b0, ab}, {31'b0, f.abort});
            else chk("frame_data", {23'b0, ok, b}, {23'b0, 1'b1, f.data});
            if (!ab && f.b2b) chk("frame_gap", start - last_end, 2);
            if (!ab) last_end = cyc;
            mon_busy = 0;
         end
      end
   end
   initial begin
      rst = 1; wen = 0; ren = 0; addr = 0; wdata = 0;
      #2 rst = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx", {31'b0, uart_tx}, 1);
      chk("reset_rdata", rdata, 0);
      chk("reset_io", uart_io_reg, 0);
      chk("reset_csr", uart_csr_reg, 32'h01B2_0004);
      @(negedge clk) rst = 1;
      @(posedge clk); #1;
      rd(1, 32'h01B2_0004);
      @(posedge clk); #1;
      chk("idle_tx", {31'b0, uart_tx}, 1);
      wr(1, 32'h0004_0000);
      send(8'h55, 4, 0, 0);
      chk("io_reg_55", uart_io_reg, 32'h55);
      measure_busy(40);
      wait_idle();
      for (int i = 0; i < 9; i++) send(8'hA0 + 8'(i), 4, i != 0, 0);
      wr(0, 32'hEE);
      rd(1, 32'h0004_080B);
      chk("io_reg_kept", uart_io_reg, 32'hA8);
      wr(1, 32'h0004_0008);
      rd(1, 32'h0004_0803);
      rd(0, 32'hA8);
      wait_idle();
      send(8'h55, 4, 0, 0);
      fq.push_back('{data: 8'hA3, div: 4, b2b: 1, abort: 0});
      rq.push_back(32'h55);
      addr = 0; wdata = 32'hA3; wen = 1; ren = 1;
      @(posedge clk); #1 wen = 0; ren = 0;
      rd(0, 32'hA3);
      wait_idle();
      send(8'h00, 4, 0, 1);
      repeat (18) @(posedge clk);
      #3 chk("bit3_low", {31'b0, uart_tx}, 0);
      rst = 0;
      #1 chk("async_tx", {31'b0, uart_tx}, 1);
      repeat (2) @(negedge clk);
      rst = 1;
      @(posedge clk); #1;
      rd(1, 32'h01B2_0004);
      chk("reset_io2", uart_io_reg, 0);
      wr(1, 32'h0000_0000);
      send(8'hFF, 0, 0, 0);
      measure_busy(10);
      wait_idle();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
